// File: rtl/plic_claim_pkg.sv
// Shared types and constants for the PLIC claim/complete agent.
// The engine FSM states and the claim register geometry live here.
package plic_claim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM,
    PRESENT,
    WAIT_DONE,
    COMPLETE
  } claim_state_e;

  localparam logic [31:0] CC_OFFSET     = 32'h0020_0004;
  localparam logic [31:0] TARGET_STRIDE = 32'h0000_1000;

endpackage

// File: rtl/reg_intf.sv
// Register-bus request/response bundles shared by all bus agents.
// 32-bit address, 32-bit data, valid/ready handshake.
package reg_intf;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;

endpackage

// File: rtl/plic_claim_engine.sv
// Claim/complete agent for one PLIC target: claims the pending ID over the
// register bus, hands it to a consumer, then writes the completion back.
module plic_claim_engine
  import plic_claim_pkg::*;
#(
  parameter int          TARGET    = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
  parameter int          SRCW      = 5,
  parameter int          HOLDOFF   = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         eip_i,
  output reg_intf::reg_intf_req_a32_d32 req_o,
  input  reg_intf::reg_intf_resp_d32    resp_i,
  output logic                         id_valid_o,
  input  logic                         id_ready_i,
  output logic [SRCW-1:0]              id_o,
  input  logic                         done_valid_i,
  output logic                         done_ready_o,
  input  logic [SRCW-1:0]              done_id_i,
  output logic                         err_o,
  output logic [15:0]                  spurious_o,
  output logic                         busy_o
);

  localparam logic [31:0] CC_ADDR =
    BASE_ADDR + CC_OFFSET + 32'(TARGET) * TARGET_STRIDE;
  localparam logic [3:0] HOLD_LD = 4'(HOLDOFF);

  claim_state_e                 state_q;
  reg_intf::reg_intf_req_a32_d32 req_q;
  logic [SRCW-1:0]              id_q;
  logic                         id_valid_q;
  logic                         done_ready_q;
  logic                         err_q;
  logic [15:0]                  spur_q;
  logic                         busy_q;
  logic [3:0]                   hold_q;

  logic [SRCW-1:0] rd_id;
  logic            unused_rdata;

  assign rd_id        = resp_i.rdata[SRCW-1:0];
  assign unused_rdata = ^resp_i.rdata[31:SRCW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= '0;
      id_q         <= '0;
      id_valid_q   <= 1'b0;
      done_ready_q <= 1'b0;
      err_q        <= 1'b0;
      spur_q       <= '0;
      busy_q       <= 1'b0;
      hold_q       <= '0;
    end else begin
      err_q <= 1'b0;
      if (hold_q != '0) hold_q <= hold_q - 4'd1;
      unique case (state_q)
        IDLE: begin
          if (eip_i && hold_q == '0) begin
            state_q     <= CLAIM;
            busy_q      <= 1'b1;
            req_q.valid <= 1'b1;
            req_q.addr  <= CC_ADDR;
            req_q.write <= 1'b0;
            req_q.wdata <= '0;
            req_q.wstrb <= 4'hF;
          end
        end
        CLAIM: begin
          if (resp_i.ready) begin
            req_q <= '0;
            if (resp_i.error || rd_id == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              hold_q  <= HOLD_LD;
              err_q   <= resp_i.error;
              if (!resp_i.error && spur_q != 16'hFFFF)
                spur_q <= spur_q + 16'd1;
            end else begin
              state_q    <= PRESENT;
              id_q       <= rd_id;
              id_valid_q <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (id_ready_i) begin
            state_q      <= WAIT_DONE;
            id_valid_q   <= 1'b0;
            done_ready_q <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (done_valid_i) begin
            state_q      <= COMPLETE;
            done_ready_q <= 1'b0;
            err_q        <= (done_id_i != id_q);
            req_q.valid  <= 1'b1;
            req_q.addr   <= CC_ADDR;
            req_q.write  <= 1'b1;
            req_q.wdata  <= 32'(id_q);
            req_q.wstrb  <= 4'hF;
          end
        end
        COMPLETE: begin
          if (resp_i.ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            req_q   <= '0;
            hold_q  <= HOLD_LD;
            err_q   <= resp_i.error;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= '0;
        end
      endcase
    end
  end

  assign req_o        = req_q;
  assign id_valid_o   = id_valid_q;
  assign id_o         = id_q;
  assign done_ready_o = done_ready_q;
  assign err_o        = err_q;
  assign spurious_o   = spur_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_plic_claim_engine.sv
// Directed bench for the PLIC claim/complete agent.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_plic_claim_engine;

  logic clk;
  logic rst;

  logic                          eip0;
  reg_intf::reg_intf_req_a32_d32 req0;
  reg_intf::reg_intf_resp_d32    resp0;
  logic                          idv0, idr0, dv0, dr0, err0, busy0;
  logic [4:0]                    id0, did0;
  logic [15:0]                   spur0;

  logic                          eip1;
  reg_intf::reg_intf_req_a32_d32 req1;
  reg_intf::reg_intf_resp_d32    resp1;
  logic                          idv1, idr1, dv1, dr1, err1, busy1;
  logic [4:0]                    id1, did1;
  logic [15:0]                   spur1;

  int n_cmp;
  int n_bad;

  plic_claim_engine #(.TARGET(0)) u_dut0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .eip_i        (eip0),
    .req_o        (req0),
    .resp_i       (resp0),
    .id_valid_o   (idv0),
    .id_ready_i   (idr0),
    .id_o         (id0),
    .done_valid_i (dv0),
    .done_ready_o (dr0),
    .done_id_i    (did0),
    .err_o        (err0),
    .spurious_o   (spur0),
    .busy_o       (busy0)
  );

  plic_claim_engine #(.TARGET(1)) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .eip_i        (eip1),
    .req_o        (req1),
    .resp_i       (resp1),
    .id_valid_o   (idv1),
    .id_ready_i   (idr1),
    .id_o         (id1),
    .done_valid_i (dv1),
    .done_ready_o (dr1),
    .done_id_i    (did1),
    .err_o        (err1),
    .spurious_o   (spur1),
    .busy_o       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(req0.valid), 32'(v));
    chk({tag, ".write"}, 32'(req0.write), 32'(w));
    chk({tag, ".addr"},  req0.addr, a);
    chk({tag, ".wdata"}, req0.wdata, d);
    chk({tag, ".wstrb"}, 32'(req0.wstrb), 32'hF);
  endtask

  localparam logic [31:0] CC0 = 32'h0C20_0004;
  localparam logic [31:0] CC1 = 32'h0C20_1004;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst  = 1'b1;
    eip0 = 0; resp0 = '0; idr0 = 0; dv0 = 0; did0 = '0;
    eip1 = 0; resp1 = '0; idr1 = 0; dv1 = 0; did1 = '0;
    tick();
    tick();
    chk("rst.req",   32'(req0),  32'h0);
    chk("rst.idv",   32'(idv0),  32'h0);
    chk("rst.dr",    32'(dr0),   32'h0);
    chk("rst.err",   32'(err0),  32'h0);
    chk("rst.busy",  32'(busy0), 32'h0);
    chk("rst.id",    32'(id0),   32'h0);
    chk("rst.spur",  32'(spur0), 32'h0);
    rst = 1'b0;
    tick();

    // basic claim/complete of source 5
    eip0 = 1;
    tick();
    chk_req("b.rd", 1, 0, CC0, 32'h0);
    chk("b.busy", 32'(busy0), 32'h1);
    eip0 = 0;
    resp0.ready = 1; resp0.rdata = 32'd5;
    tick();
    chk("b.idv", 32'(idv0), 32'h1);
    chk("b.id",  32'(id0),  32'd5);
    chk("b.rv",  32'(req0.valid), 32'h0);
    resp0 = '0;
    idr0 = 1;
    tick();
    chk("b.idv0", 32'(idv0), 32'h0);
    chk("b.dr",   32'(dr0),  32'h1);
    idr0 = 0;
    dv0 = 1; did0 = 5'd5;
    tick();
    chk_req("b.wr", 1, 1, CC0, 32'd5);
    chk("b.err", 32'(err0), 32'h0);
    chk("b.dr0", 32'(dr0),  32'h0);
    dv0 = 0;
    resp0.ready = 1;
    tick();
    chk("b.idle.v",    32'(req0.valid), 32'h0);
    chk("b.idle.busy", 32'(busy0),      32'h0);
    resp0 = '0;

    // holdoff after completion: claim launches on the 4th edge
    eip0 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ho.wait", 32'(req0.valid), 32'h0);
    end
    tick();
    chk_req("ho.rd", 1, 0, CC0, 32'h0);

    // spurious claim
    eip0 = 0;
    resp0.ready = 1; resp0.rdata = 32'h0;
    tick();
    chk("sp.cnt",  32'(spur0), 32'd1);
    chk("sp.idv",  32'(idv0),  32'h0);
    chk("sp.busy", 32'(busy0), 32'h0);
    chk("sp.err",  32'(err0),  32'h0);
    resp0 = '0;
    eip0 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sp.wait", 32'(req0.valid), 32'h0);
    end
    tick();
    chk_req("sp.rd", 1, 0, CC0, 32'h0);

    // backpressure on read, then on id hand-off
    eip0 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_req("bp.rd", 1, 0, CC0, 32'h0);
    end
    resp0.ready = 1; resp0.rdata = 32'd9;
    tick();
    resp0 = '0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.idv", 32'(idv0), 32'h1);
      chk("bp.id",  32'(id0),  32'd9);
      tick();
    end
    chk("bp.idv3", 32'(idv0), 32'h1);
    // id_ready and done_valid together: only the id handshake is taken
    idr0 = 1; dv0 = 1; did0 = 5'd9;
    tick();
    chk("sim.dr", 32'(dr0), 32'h1);
    chk("sim.rv", 32'(req0.valid), 32'h0);
    idr0 = 0;
    tick();
    chk_req("sim.wr", 1, 1, CC0, 32'd9);
    dv0 = 0;
    tick();
    chk_req("bp.wr", 1, 1, CC0, 32'd9);
    resp0.ready = 1;
    tick();
    chk("bp.idle", 32'(busy0), 32'h0);
    resp0 = '0;

    // id mismatch: claim 7, complete with 3
    eip0 = 1;
    repeat (4) tick();
    chk("mm.rv", 32'(req0.valid), 32'h1);
    eip0 = 0;
    resp0.ready = 1; resp0.rdata = 32'd7;
    tick();
    resp0 = '0;
    idr0 = 1;
    tick();
    idr0 = 0;
    dv0 = 1; did0 = 5'd3;
    tick();
    dv0 = 0;
    chk("mm.err", 32'(err0), 32'h1);
    chk_req("mm.wr", 1, 1, CC0, 32'd7);
    tick();
    chk("mm.err0", 32'(err0), 32'h0);
    resp0.ready = 1;
    tick();
    resp0 = '0;

    // bus error on claim read, eip stays high
    eip0 = 1;
    repeat (4) tick();
    chk("be.rv", 32'(req0.valid), 32'h1);
    resp0.ready = 1; resp0.error = 1; resp0.rdata = 32'd4;
    tick();
    chk("be.err",  32'(err0),  32'h1);
    chk("be.busy", 32'(busy0), 32'h0);
    chk("be.idv",  32'(idv0),  32'h0);
    resp0 = '0;
    tick();
    chk("be.err0", 32'(err0), 32'h0);
    repeat (2) tick();
    chk("be.wait", 32'(req0.valid), 32'h0);
    tick();
    chk_req("be.rd", 1, 0, CC0, 32'h0);

    // reset while the completion write is pending
    eip0 = 0;
    resp0.ready = 1; resp0.rdata = 32'd4;
    tick();
    resp0 = '0;
    idr0 = 1;
    tick();
    idr0 = 0;
    dv0 = 1; did0 = 5'd4;
    tick();
    dv0 = 0;
    chk("rc.wv", 32'(req0.valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("rc.rv",   32'(req0.valid), 32'h0);
    chk("rc.req",  32'(req0),  32'h0);
    chk("rc.busy", 32'(busy0), 32'h0);
    chk("rc.idv",  32'(idv0),  32'h0);
    chk("rc.id",   32'(id0),   32'h0);
    chk("rc.spur", 32'(spur0), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // target 1 address
    eip1 = 1;
    tick();
    chk("t1.v",    32'(req1.valid), 32'h1);
    chk("t1.addr", req1.addr, CC1);
    chk("t1.w",    32'(req1.write), 32'h0);
    eip1 = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/plic_claim_engine.md
# plic_claim_engine

Hardware claim/complete agent for one PLIC target. Watches the target's external-interrupt line, reads the target's claim/complete register over the `reg_intf` register bus to obtain the source ID, and hands the ID to a consumer over a valid/ready port. It then takes the consumer's completion and writes the ID back to the same register. It sits directly downstream of `plic_top`, one instance per target, sharing the bus with software through the system register crossbar.

## Interface
**Parameters**
- `TARGET`, default 0: PLIC target index this instance serves.
- `BASE_ADDR`, default 32'h0C00_0000: PLIC base address.
- `SRCW`, default 5: source-ID width; must match the PLIC.
- `HOLDOFF`, default 3: idle cycles after a completion before `eip_i` is sampled again; legal range 1–15.

**Ports**
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `eip_i` in 1: target interrupt from the PLIC (`eip_targets_o[TARGET]`).
- `req_o` out `reg_intf::reg_intf_req_a32_d32`: bus request.
- `resp_i` in `reg_intf::reg_intf_resp_d32`: bus response.
- `id_valid_o` out 1: claimed ID available.
- `id_ready_i` in 1: consumer accepts the ID.
- `id_o` out SRCW: claimed source ID.
- `done_valid_i` in 1: consumer finished servicing.
- `done_ready_o` out 1: engine accepts completion.
- `done_id_i` in SRCW: ID being completed.
- `err_o` out 1: one-cycle error pulse.
- `spurious_o` out 16: saturating count of claims that returned ID 0.
- `busy_o` out 1: state is not IDLE.

## Operation
- Claim/complete address: `CC_ADDR = BASE_ADDR + 32'h20_0004 + TARGET*32'h1000`. All accesses use `wstrb = 4'hF`.
- **IDLE**
  - `req_o.valid = 0`.
  - If `eip_i = 1` and the holdoff counter is 0, go to CLAIM.
- **CLAIM**
  - Drive a read of `CC_ADDR` and hold it until `resp_i.ready`.
  - On ready with `error = 1`: pulse `err_o`, go to IDLE. The holdoff counter is loaded.
  - On ready with `rdata[SRCW-1:0] = 0`: increment `spurious_o`, saturating at 16'hFFFF. Go to IDLE; the holdoff counter is loaded.
  - On ready otherwise: register the ID in `id_q` and go to PRESENT.
- **PRESENT**
  - `id_valid_o = 1`, `id_o = id_q`.
  - On `id_ready_i`, go to WAIT_DONE.
- **WAIT_DONE**
  - `done_ready_o = 1`.
  - On `done_valid_i`, go to COMPLETE.
  - If `done_id_i != id_q`, pulse `err_o`. The completion write still uses `id_q`, so the gateway is never left blocked.
- **COMPLETE**
  - Drive a write of `CC_ADDR` with `wdata = {'0, id_q}`; hold until `resp_i.ready`.
  - On ready, go to IDLE and load the holdoff counter with HOLDOFF.
  - If `error = 1`, also pulse `err_o`. There is no retry.
- **Holdoff counter**
  - Decrements by 1 per cycle while nonzero, in any state.
  - Covers the PLIC's registered `irq` lag after a claim or complete.
- Only one interrupt is outstanding per instance.
- `eip_i` is ignored outside IDLE.
- `done_valid_i` is ignored outside WAIT_DONE.

## Timing
- **Reset values:** state IDLE; `req_o = '0`; `id_valid_o`, `done_ready_o`, `err_o`, `busy_o` all 0; `id_o = 0`; `spurious_o = 0`; holdoff counter 0.
- **Registered outputs:** all outputs are registered. Request fields are stable while `valid = 1 && ready = 0`.
- **Claim launch:** `eip_i` high in IDLE at cycle N gives `req_o.valid` at N+1.
- **ID hand-off:** `resp_i.ready` at cycle M in CLAIM gives `id_valid_o` at M+1.
- **Completion launch:** `done_valid_i` handshake at cycle K gives the completion write valid at K+1.
- **Holdoff after completion:**
  - Write ready at cycle J puts the engine in IDLE at J+1, with the counter at HOLDOFF.
  - The earliest re-claim has `req_o.valid` at J+HOLDOFF+2.
- **Asynchronous reset mid-transaction:** `req_o.valid` drops immediately and the engine returns to IDLE. A claimed-but-uncompleted ID stays blocked in the PLIC gateway; the system resets the PLIC together with this block.
- **Simultaneous events:** `id_ready_i` and `done_valid_i` in the same cycle in PRESENT take only the ID handshake. The done is taken in WAIT_DONE, earliest one cycle later.

## Structure
- Shared package `plic_claim_pkg` holds:
  - state enum `claim_state_e` (IDLE, CLAIM, PRESENT, WAIT_DONE, COMPLETE);
  - constants `CC_OFFSET = 32'h20_0004` and `TARGET_STRIDE = 32'h1000`.
- A single flat module; no sub-module is needed.
- The spurious counter and holdoff counter are inline registers.

## Test plan
- **Basic claim/complete:** source 5 pends, `eip_i` rises.
  - Read at `0x0C20_0004`; `rdata = 5` gives `id_o = 5`.
  - After `done_id_i = 5`, write 5 to `0x0C20_0004`; engine returns to IDLE.
- **Spurious claim:** `eip_i` pulse, `rdata = 0`.
  - `spurious_o = 1`, no `id_valid_o`.
  - No new read until HOLDOFF cycles have elapsed.
- **Backpressure:** bus `ready` delayed 4 cycles, `id_ready_i` delayed 3 cycles.
  - Request fields stay stable throughout.
  - `id_valid_o` is held until accepted.
- **ID mismatch:** claim 7, `done_id_i = 3`.
  - `err_o` pulses.
  - The completion write carries 7.
- **Bus error:** claim read returns `error = 1`.
  - `err_o` pulses; engine returns to IDLE.
  - With `eip_i` still high, a re-claim is issued after holdoff.
- **Reset during COMPLETE:** `rst_i` asserted while the write is pending.
  - `req_o.valid = 0` in the same cycle.
  - All outputs return to reset values.
  - TARGET=1 instance then reads `0x0C20_1004`.
